// File: rtl/risc_toy_pkg.sv
// rtl/risc_toy_pkg.sv - shared types and constants for the RISC_TOY memory arbiter
//
// Purpose: arbiter state encoding, memory direction constants and default
// address/data widths shared by the arbiter and its users.
// Ports: none (package).

package risc_toy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int AW_DEFAULT = 30;
  localparam int DW_DEFAULT = 32;

endpackage

// File: rtl/risc_toy_mem_arbiter.sv
// rtl/risc_toy_mem_arbiter.sv - fetch/data arbiter in front of a single-ported memory
//
// Purpose: serialises RISC_TOY instruction-fetch and data requests onto one
// external memory port, one outstanding transaction at a time. Data wins over
// fetch, except that after MAX_DSTREAK consecutive data grants with a fetch
// waiting, the fetch is served next.
// Optional feature: define MEMARB_TIMEOUT_EN to add a busy-cycle watchdog that
// abandons a transaction after TIMEOUT_CYC cycles and flags it on ERR.
// Ports:
//   CLK, RSTN                       clock, asynchronous active-low reset
//   I_REQ/I_ADDR -> I_ACK/I_RDATA   fetch requester
//   D_REQ/D_RW/D_ADDR/D_WDATA
//     -> D_ACK/D_RDATA              data requester
//   ERR                             pulses with a timed-out ACK (0 without watchdog)
//   M_REQ/M_RW/M_ADDR/M_WDATA
//     <- M_ACK/M_RDATA              memory side, outputs registered

module risc_toy_mem_arbiter
  import risc_toy_pkg::*;
#(
  parameter int AW          = AW_DEFAULT,
  parameter int DW          = DW_DEFAULT,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_ACK,
  output logic [DW-1:0] I_RDATA,
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_ACK,
  output logic [DW-1:0] D_RDATA,
  output logic          ERR,
  output logic          M_REQ,
  output logic          M_RW,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic          M_ACK,
  input  logic [DW-1:0] M_RDATA
);

  generate
    if (MAX_DSTREAK < 1 || MAX_DSTREAK > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 127) begin : g_bad_params
      $error("risc_toy_mem_arbiter: MAX_DSTREAK must be 1..15 and TIMEOUT_CYC 1..127");
    end
  endgenerate

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  arb_state_e    state_q, state_d;
  logic [3:0]    streak_q, streak_d;
  logic          m_req_q, m_req_d;
  logic          m_rw_q, m_rw_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          grant_d;
  logic          finish;
  logic          timed_out;

`ifdef MEMARB_TIMEOUT_EN
  localparam logic [6:0] WDOG_LAST = 7'(TIMEOUT_CYC - 1);
  logic [6:0] wdog_q, wdog_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    m_req_d   = m_req_q;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    finish    = 1'b0;
    timed_out = 1'b0;
    // Data wins unless a waiting fetch has already been passed over STREAK_MAX times.
    grant_d   = D_REQ && !(I_REQ && streak_q == STREAK_MAX);
`ifdef MEMARB_TIMEOUT_EN
    wdog_d    = wdog_q;
    err_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
`ifdef MEMARB_TIMEOUT_EN
        wdog_d = 7'd0;
`endif
        if (!I_REQ) begin
          streak_d = 4'd0;
        end
        if (grant_d) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_rw_d    = D_RW;
          m_addr_d  = D_ADDR;
          m_wdata_d = D_WDATA;
          if (I_REQ && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (I_REQ) begin
          state_d  = BUSY_I;
          m_req_d  = 1'b1;
          m_rw_d   = RW_READ;
          m_addr_d = I_ADDR;
          streak_d = 4'd0;
        end
      end

      BUSY_I, BUSY_D: begin
        finish = M_ACK;
`ifdef MEMARB_TIMEOUT_EN
        // A memory ACK in the last watchdog cycle still completes normally.
        if (!M_ACK) begin
          if (wdog_q == WDOG_LAST) begin
            finish    = 1'b1;
            timed_out = 1'b1;
          end else begin
            wdog_d = wdog_q + 7'd1;
          end
        end
        err_d = timed_out;
`endif
        // Always pass through IDLE so the ACK cycle never issues a new grant.
        if (finish) begin
          m_req_d = 1'b0;
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            i_ack_d = 1'b1;
            if (!timed_out) begin
              i_rdata_d = M_RDATA;
            end
          end else begin
            d_ack_d = 1'b1;
            if (!timed_out && m_rw_q != RW_WRITE) begin
              d_rdata_d = M_RDATA;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      streak_q  <= 4'd0;
      m_req_q   <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      m_req_q   <= m_req_d;
      m_rw_q    <= m_rw_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef MEMARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wdog_q <= 7'd0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign I_ACK   = i_ack_q;
  assign I_RDATA = i_rdata_q;
  assign D_ACK   = d_ack_q;
  assign D_RDATA = d_rdata_q;
  assign M_REQ   = m_req_q;
  assign M_RW    = m_rw_q;
  assign M_ADDR  = m_addr_q;
  assign M_WDATA = m_wdata_q;

endmodule

// File: tb/tb_risc_toy_mem_arbiter.sv
// tb/tb_risc_toy_mem_arbiter.sv - self-checking bench for risc_toy_mem_arbiter

module tb_risc_toy_mem_arbiter;

  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TMO  = 64;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic          I_ACK;
  logic [DW-1:0] I_RDATA;
  logic          D_REQ;
  logic          D_RW;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_ACK;
  logic [DW-1:0] D_RDATA;
  logic          ERR;
  logic          M_REQ;
  logic          M_RW;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_WDATA;
  logic          M_ACK;
  logic [DW-1:0] M_RDATA;

  always #5 CLK = ~CLK;

  risc_toy_mem_arbiter #(
    .AW(AW), .DW(DW), .MAX_DSTREAK(MAXS), .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA), .ERR(ERR),
    .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_ACK(M_ACK), .M_RDATA(M_RDATA)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: each requester is idle, waiting for a grant or in flight.
  typedef enum int {R_IDLE, R_WAIT, R_FLY} rq_e;
  rq_e           i_st, d_st;
  logic [AW-1:0] i_a, d_a;
  logic          d_w;
  logic [DW-1:0] d_wd;
  bit            busy;
  bit            own_d;
  int            wait_left;
  int            busy_cyc;
  int            streak;
  int            force_wait;
  int            p_i, p_d;
  bit            use_fix;
  logic [DW-1:0] fix_rdata;
  logic [DW-1:0] exp_irdata, exp_drdata;
  bit            grants_q[$];

  task automatic model_reset();
    busy = 0; own_d = 0; wait_left = 0; busy_cyc = 0; streak = 0;
    i_st = R_IDLE; d_st = R_IDLE;
    exp_irdata = '0; exp_drdata = '0;
    I_REQ = 0; D_REQ = 0; M_ACK = 0; M_RDATA = '0;
  endtask

  task automatic grant(input bit to_d);
    busy = 1; own_d = to_d; busy_cyc = 0;
    wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
    if (to_d) d_st = R_FLY; else i_st = R_FLY;
    grants_q.push_back(to_d);
  endtask

  task automatic start_i(input logic [AW-1:0] a);
    i_st = R_WAIT; i_a = a; I_ADDR = a; I_REQ = 1;
  endtask

  task automatic start_d(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_st = R_WAIT; d_w = rw; d_a = a; d_wd = wd;
    D_RW = rw; D_ADDR = a; D_WDATA = wd; D_REQ = 1;
  endtask

  // One clock: evaluate the edge that just passed, check outputs, then drive the next cycle.
  task automatic step();
    bit comp, cerr, exp_ia, exp_da, iw, dw;
    @(negedge CLK);
    comp = 0; cerr = 0; exp_ia = 0; exp_da = 0;
    if (busy) begin
      if (M_ACK) comp = 1;
      else begin
        busy_cyc++;
`ifdef MEMARB_TIMEOUT_EN
        if (busy_cyc == TMO) begin comp = 1; cerr = 1; end
`endif
      end
    end else begin
      iw = (i_st == R_WAIT);
      dw = (d_st == R_WAIT);
      if (dw && (!iw || streak < MAXS)) begin
        streak = iw ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        grant(1);
      end else if (iw) begin
        streak = 0;
        grant(0);
      end else begin
        streak = 0;
      end
    end
    if (comp) begin
      busy = 0;
      if (own_d) begin
        exp_da = 1; d_st = R_IDLE;
        if (!cerr && !d_w) exp_drdata = M_RDATA;
      end else begin
        exp_ia = 1; i_st = R_IDLE;
        if (!cerr) exp_irdata = M_RDATA;
      end
    end

    check("m_req", 64'(M_REQ), 64'(busy));
    if (busy) begin
      check("m_addr", 64'(M_ADDR), 64'(own_d ? d_a : i_a));
      check("m_rw", 64'(M_RW), 64'(own_d ? d_w : 1'b0));
      if (own_d && d_w) check("m_wdata", 64'(M_WDATA), 64'(d_wd));
    end
    check("i_ack", 64'(I_ACK), 64'(exp_ia));
    check("d_ack", 64'(D_ACK), 64'(exp_da));
    check("err", 64'(ERR), 64'(cerr));
    check("i_rdata", 64'(I_RDATA), 64'(exp_irdata));
    check("d_rdata", 64'(D_RDATA), 64'(exp_drdata));

    if (busy) begin
      if (wait_left == 0) M_ACK = 1;
      else begin M_ACK = 0; wait_left--; end
    end else begin
      M_ACK = 0;
    end
    M_RDATA = use_fix ? fix_rdata : $urandom;
    if (i_st == R_IDLE && int'($urandom_range(0, 99)) < p_i) begin
      i_st = R_WAIT; i_a = AW'($urandom);
    end
    if (d_st == R_IDLE && int'($urandom_range(0, 99)) < p_d) begin
      d_st = R_WAIT; d_w = 1'($urandom); d_a = AW'($urandom); d_wd = $urandom;
    end
    I_REQ = (i_st != R_IDLE); I_ADDR = i_a;
    D_REQ = (d_st != R_IDLE); D_RW = d_w; D_ADDR = d_a; D_WDATA = d_wd;
  endtask

  initial begin
    RSTN = 0; force_wait = 0; p_i = 0; p_d = 0; use_fix = 0; fix_rdata = '0;
    i_a = '0; d_a = '0; d_w = 0; d_wd = '0;
    I_ADDR = '0; D_RW = 0; D_ADDR = '0; D_WDATA = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_m_req", 64'(M_REQ), 64'd0);
    check("rst_m_addr", 64'(M_ADDR), 64'd0);
    check("rst_m_wdata", 64'(M_WDATA), 64'd0);
    check("rst_m_rw", 64'(M_RW), 64'd0);
    check("rst_acks", 64'({I_ACK, D_ACK, ERR}), 64'd0);
    check("rst_rdata", 64'({I_RDATA, D_RDATA}), 64'd0);
    RSTN = 1;

    // Single fetch with same-cycle memory ACK.
    use_fix = 1; fix_rdata = 32'hDEADBEEF;
    start_i(AW'(32'h10));
    repeat (4) step();
    check("fetch_data", 64'(I_RDATA), 64'h0000_0000_DEAD_BEEF);
    use_fix = 0;

    // Data write with three memory wait cycles.
    force_wait = 3;
    start_d(1'b1, AW'(32'h20), 32'h55AA55AA);
    repeat (8) step();
    check("write_keeps_rdata", 64'(D_RDATA), 64'd0);

    // Both requesters held: data streak of MAX_DSTREAK, then one fetch.
    force_wait = 0; p_i = 100; p_d = 100;
    grants_q.delete();
    repeat (24) step();
    check("streak_grants", 64'(grants_q.size() >= 10), 64'd1);
    for (int k = 0; k < 10 && k < grants_q.size(); k++)
      check("streak_order", 64'(grants_q[k]), 64'((k % 5) != 4));
    p_i = 0; p_d = 0;
    repeat (12) step();

    // Reset while a data transaction waits on memory.
    force_wait = 1000;
    start_d(1'b0, AW'(32'h33), '0);
    repeat (4) step();
    #2 RSTN = 0;
    #1;
    check("rst_mid_m_req", 64'(M_REQ), 64'd0);
    check("rst_mid_d_ack", 64'(D_ACK), 64'd0);
    model_reset();
    @(negedge CLK);
    check("rst_mid_outs", 64'({M_REQ, I_ACK, D_ACK, ERR}), 64'd0);
    RSTN = 1;
    force_wait = 0;
    start_d(1'b0, AW'(32'h44), '0);
    repeat (4) step();

`ifdef MEMARB_TIMEOUT_EN
    // Memory never answers: watchdog completes with ERR.
    force_wait = 1000;
    start_d(1'b0, AW'(32'h55), '0);
    repeat (70) step();
`endif
    // Memory answers in the 64th busy cycle: normal completion.
    force_wait = TMO - 1;
    start_d(1'b0, AW'(32'h66), '0);
    repeat (70) step();

    // Randomised traffic with random memory latency.
    force_wait = -1; p_i = 40; p_d = 50;
    repeat (3000) step();
    p_i = 0; p_d = 0;
    repeat (20) step();
    check("drained", 64'(busy || M_REQ), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
